// File: rtl/debug_disp_arbiter.sv
// Round-robin owner selection for the shared 4-digit debug display, with a minimum dwell and a blanking gap between owners.
// Optional build macro DISP_ARB_PRIO_EN makes requester 3 a preempting priority source.
module debug_disp_arbiter #(
  parameter int               CNT_W = 24,
  parameter logic [CNT_W-1:0] DWELL = 24'd12_500_000,
  parameter logic [CNT_W-1:0] BLANK = 24'd1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [15:0] data0,
  input  logic [15:0] data1,
  input  logic [15:0] data2,
  input  logic [15:0] data3,
  input  logic        lock,
  output logic [3:0]  grant,
  output logic [15:0] num,
  output logic        blank,
  output logic [3:0]  ack
);

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_SHOW} state_t;

  localparam logic [CNT_W-1:0] DWELL_LAST = DWELL - 1'b1;
  localparam logic [CNT_W-1:0] BLANK_LAST = BLANK - 1'b1;

  state_t           state_q, state_d;
  logic [1:0]       owner_q, owner_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      num_q, num_d;
  logic [3:0]       ack_q, ack_d;
  logic [15:0]      owner_data;
  logic [1:0]       sel;

  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    logic       found;
    rr_pick = p;
    found   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = p + 2'(i);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
`ifdef DISP_ARB_PRIO_EN
    if (r[3]) rr_pick = 2'd3;
`endif
  endfunction

  // Requester 3 never moves the pointer when it is the priority source.
  function automatic logic [1:0] ptr_after(input logic [1:0] owner, input logic [1:0] ptr);
`ifdef DISP_ARB_PRIO_EN
    ptr_after = (owner == 2'd3) ? ptr : owner + 2'd1;
`else
    ptr_after = owner + 2'd1;
    if (ptr == owner) ptr_after = owner + 2'd1;
`endif
  endfunction

`ifdef DISP_ARB_PRIO_EN
  logic req3_q;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) req3_q <= 1'b0;
    else       req3_q <= req[3];
  end
`endif

  always_comb begin
    case (owner_q)
      2'd0:    owner_data = data0;
      2'd1:    owner_data = data1;
      2'd2:    owner_data = data2;
      default: owner_data = data3;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      owner_q <= 2'd0;
      ptr_q   <= 2'd0;
      cnt_q   <= '0;
      num_q   <= '0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      ack_q   <= ack_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    ack_d   = '0;
    sel     = 2'd0;
    case (state_q)
      S_IDLE: begin
        if (req != 4'd0) begin
          owner_d = rr_pick(req, ptr_q);
          cnt_d   = '0;
          state_d = S_BLANK;
        end
      end
      S_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          cnt_d   = '0;
          state_d = S_SHOW;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SHOW: begin
        // Dwell end takes precedence over the owner dropping its request.
        if (lock) begin
          cnt_d = cnt_q;
        end else if (cnt_q == DWELL_LAST) begin
          ack_d = 4'b0001 << owner_q;
          ptr_d = ptr_after(owner_q, ptr_q);
          cnt_d = '0;
          if (req == 4'd0) begin
            state_d = S_IDLE;
          end else begin
            sel = rr_pick(req, ptr_d);
            if (sel != owner_q) begin
              owner_d = sel;
              state_d = S_BLANK;
            end
          end
        end else if (!req[owner_q]) begin
          ptr_d   = ptr_after(owner_q, ptr_q);
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_q == S_SHOW || (state_q == S_BLANK && state_d == S_SHOW)) num_d = owner_data;
`ifdef DISP_ARB_PRIO_EN
    if ((state_q == S_SHOW || state_q == S_BLANK) && owner_q != 2'd3 && req[3] && !req3_q) begin
      owner_d = 2'd3;
      state_d = S_BLANK;
      cnt_d   = '0;
      ptr_d   = ptr_q;
      ack_d   = '0;
    end
`endif
  end

  always_comb begin
    grant = (state_q == S_IDLE) ? 4'd0 : (4'b0001 << owner_q);
    blank = (state_q != S_SHOW);
    num   = num_q;
    ack   = ack_q;
  end

endmodule

// File: tb/tb_debug_disp_arbiter.sv
// Randomized bench for debug_disp_arbiter (DWELL=8, BLANK=2) against an owner/phase-count reference model.
module tb_debug_disp_arbiter;

  localparam int DW = 8;
  localparam int BK = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req   = 4'd0;
  logic [15:0] data0 = 16'd0, data1 = 16'd0, data2 = 16'd0, data3 = 16'd0;
  logic        lock  = 1'b0;
  logic [3:0]  grant;
  logic [15:0] num;
  logic        blank;
  logic [3:0]  ack;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: who owns the display, how far it is through blank/show.
  int          m_owner;
  bit          m_show;
  int          m_blank_left;
  int          m_shown;
  int          m_ptr;
  logic [15:0] m_num;
  logic [3:0]  m_ack;

  debug_disp_arbiter #(.CNT_W(24), .DWELL(24'd8), .BLANK(24'd2)) dut (
    .clock(clock), .reset(reset), .req(req),
    .data0(data0), .data1(data1), .data2(data2), .data3(data3),
    .lock(lock), .grant(grant), .num(num), .blank(blank), .ack(ack)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int p);
    for (int i = 0; i < 4; i++) begin
      if (r[(p + i) % 4]) return (p + i) % 4;
    end
    return -1;
  endfunction

  function automatic logic [15:0] dsel(input int k);
    case (k)
      0:       return data0;
      1:       return data1;
      2:       return data2;
      default: return data3;
    endcase
  endfunction

  task automatic model_reset();
    m_owner = -1; m_show = 0; m_blank_left = 0; m_shown = 0;
    m_ptr = 0; m_num = 16'd0; m_ack = 4'd0;
  endtask

  task automatic model_step();
    int nxt;
    m_ack = 4'd0;
    if (m_owner < 0) begin
      if (req != 4'd0) begin
        m_owner = pick(req, m_ptr);
        m_show = 0;
        m_blank_left = BK;
      end
    end else if (!m_show) begin
      m_blank_left--;
      if (m_blank_left == 0) begin
        m_show = 1;
        m_shown = 0;
        m_num = dsel(m_owner);
      end
    end else begin
      m_num = dsel(m_owner);
      if (!lock) begin
        m_shown++;
        if (m_shown == DW) begin
          m_ack = 4'(1 << m_owner);
          m_ptr = (m_owner + 1) % 4;
          m_shown = 0;
          if (req == 4'd0) begin
            m_owner = -1;
            m_show = 0;
          end else begin
            nxt = pick(req, m_ptr);
            if (nxt != m_owner) begin
              m_owner = nxt;
              m_show = 0;
              m_blank_left = BK;
            end
          end
        end else if (!req[m_owner]) begin
          m_ptr = (m_owner + 1) % 4;
          m_owner = -1;
          m_show = 0;
        end
      end
    end
  endtask

  task automatic compare_outputs();
    logic [3:0] eg;
    eg = (m_owner < 0) ? 4'd0 : 4'(1 << m_owner);
    check("grant", 32'(grant), 32'(eg));
    check("blank", 32'(blank), 32'(!m_show));
    check("num", 32'(num), 32'(m_num));
    check("ack", 32'(ack), 32'(m_ack));
    check("grant_onehot", 32'($countones(grant) <= 1), 32'd1);
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    compare_outputs();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_show(input logic [3:0] g);
    for (int i = 0; i < 60; i++) begin
      if (grant == g && !blank) break;
      tick();
    end
    check("wait_show", 32'(grant & {4{!blank}}), 32'(g));
  endtask

  task automatic async_reset();
    reset = 1'b1;
    #1;
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_blank", 32'(blank), 32'd1);
    check("rst_num", 32'(num), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    model_reset();
    #2;
    reset = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check("init_grant", 32'(grant), 32'd0);
    check("init_blank", 32'(blank), 32'd1);
    check("init_num", 32'(num), 32'd0);
    check("init_ack", 32'(ack), 32'd0);
    reset = 1'b0;

    // Single requester: blank, show, ack, then continuous show.
    data0 = 16'h1234;
    req = 4'b0001;
    ticks(25);

    // Two requesters alternate with a blank gap each switch.
    data2 = 16'hABCD;
    req = 4'b0101;
    ticks(40);

    // Owner 2 drops its request partway through the dwell.
    wait_show(4'b0100);
    ticks(3);
    req = 4'b0001;
    ticks(15);

    // Lock holds owner 1 past its dwell.
    data1 = 16'h5A5A;
    req = 4'b0010;
    wait_show(4'b0010);
    ticks(3);
    lock = 1'b1;
    ticks(20);
    lock = 1'b0;
    ticks(15);

    // Asynchronous reset during a blank phase.
    req = 4'b1000;
    for (int i = 0; i < 40; i++) begin
      if (blank && grant == 4'b1000) break;
      tick();
    end
    check("pre_rst_blank", 32'(grant & {4{blank}}), 32'h8);
    #2;
    async_reset();
    ticks(12);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 11) == 0) req = 4'($urandom_range(0, 15));
      if (lock) begin
        if ($urandom_range(0, 3) == 0) lock = 1'b0;
      end else if ($urandom_range(0, 29) == 0) begin
        lock = 1'b1;
      end
      if ($urandom_range(0, 3) == 0) data0 = 16'($urandom);
      if ($urandom_range(0, 3) == 0) data1 = 16'($urandom);
      if ($urandom_range(0, 3) == 0) data2 = 16'($urandom);
      if ($urandom_range(0, 3) == 0) data3 = 16'($urandom);
      if (c == 1500) begin
        #2;
        async_reset();
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/debug_disp_arbiter.md
Name: debug_disp_arbiter

Overview:
- Shares the single 4-digit seven-segment debug display between up to four requesters, e.g. CPU test_out low/high, PC, clock count and a fault monitor.
- Round-robin grant with a minimum dwell time per requester and a blanking gap between switches.
- Drives the 16-bit value into the display multiplexer. Sits between the CPU debug taps and the display scanner.

Parameters:
- CNT_W, 24, width of the dwell/blank counter.
- DWELL, 24'd12_500_000, cycles a granted value is shown (0.25 s at 50 MHz); legal range 1..2^CNT_W-1.
- BLANK, 24'd1024, cycles of forced blank between different grants; legal range 1..DWELL.

Ports:
- clock  in  1  system clock, all state on posedge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- req  in  4  per-requester display request, level-sensitive.
- data0  in  16  value of requester 0.
- data1  in  16  value of requester 1.
- data2  in  16  value of requester 2.
- data3  in  16  value of requester 3.
- lock  in  1  freeze current grant; dwell counter holds while high in SHOW.
- grant  out  4  one-hot current owner, 0 when idle.
- num  out  16  value to display, registered.
- blank  out  1  display must be dark.
- ack  out  4  one-cycle pulse on the owner's bit when its full dwell completes.

Behaviour:
- Reset values: state=IDLE, grant=0, num=0, blank=1, ack=0, counter=0, rr pointer=0.
- State IDLE:
  - blank=1, grant=0.
  - If req!=0, select the first set bit scanning from pointer upward with wrap 3->0. Load grant, counter=0, go to BLANK.
- State BLANK:
  - blank=1; counter increments each cycle.
  - When counter==BLANK-1: counter=0, go to SHOW.
- State SHOW:
  - blank=0; num <= data of owner every cycle, so value updates are live with 1-cycle latency.
  - Counter increments each cycle unless lock=1 (holds).
  - Owner's req drops while lock=0: abort next cycle, no ack, pointer=owner+1, return to IDLE (re-arbitration next cycle).
  - Owner's req drops while lock=1: ignored until lock clears.
  - Counter==DWELL-1 with lock=0:
    - Pulse ack[owner] for one cycle; pointer=owner+1 mod 4.
    - If another requester is pending, select it by the same scan, go to BLANK.
    - If only the owner still requests, stay in SHOW with counter=0 and no blank cycle.
    - If req==0, go to IDLE.
- Width and counters:
  - Counter is CNT_W bits and never wraps: it compares to DWELL-1 and BLANK-1 and is cleared on every transition.
- Invariants:
  - grant is always one-hot or zero.
  - num holds its last SHOW value during BLANK/IDLE; the display must honour blank.
- Simultaneous events:
  - Owner req drop in the same cycle as dwell end: ack is issued (dwell completed), then normal end-of-dwell transition.
  - lock rising in the same cycle as dwell end: lock wins, no transition, counter holds at DWELL-1.
- Reset mid-operation: outputs return to reset values asynchronously, with no ack pulse.

Optional Feature:
- Macro DISP_ARB_PRIO_EN.
- Defined: requester 3 is priority.
  - req[3] rising while another owner is in SHOW or BLANK preempts it at the next clock regardless of lock: no ack to the preempted owner, grant=4'b1000, go to BLANK.
  - Requester 3 always wins arbitration when set.
  - The pointer is not updated by requester 3's grants.
- Not defined: requester 3 is an ordinary round-robin peer; no preemption logic is synthesised.

Test Plan (DWELL=8, BLANK=2):
- Reset, then req=4'b0001, data0=16'h1234 -> grant=0001 next cycle; blank=1 for 2 cycles; then num=1234, blank=0 for 8 cycles; ack=0001 one cycle; with req held, stays in SHOW with no blank.
- req=4'b0101 held -> grants alternate 0001, 0100, 0001; each switch has exactly 2 blank cycles; ack pulses alternate 0001/0100.
- Owner 2 in SHOW, req[2] drops at dwell cycle 3 -> IDLE next cycle, no ack; a pending req[0] is granted the following cycle.
- lock=1 for 20 cycles mid-SHOW of owner 1 -> grant stays 0010, no ack; after lock=0, the remaining dwell cycles complete, then ack=0010.
- reset asserted during BLANK -> grant=0, blank=1, num=0 immediately without a clock edge; no ack.
- With DISP_ARB_PRIO_EN, owner 0 in SHOW and req[3] rises -> next cycle grant=1000, blank=1, no ack to 0; after 2+8 cycles ack=1000, then grant returns to 0001.
